// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide responder beside the E-stage ALU.
// The result is computed in the issue cycle into the shadow registers
// (hi_n/lo_n). It is committed to HI/LO after a fixed latency, which
// matches the iterative unit this block stands in for.
// Optional feature: define MDU_CANCEL_EN to add the `cancel` flush input.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        we,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int DATA_W     = 32;
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] CNT_IDLE = '0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   hi_n;
  logic [DATA_W-1:0]   lo_n;
  logic [2*DATA_W-1:0] res;
  logic                is_div;
  logic                div_zero;
  logic                start_ok;

  // Signed 64-bit product; the operands are sign-extended before multiplying.
  function automatic logic [2*DATA_W-1:0] mul_signed(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ae;
    logic signed [2*DATA_W-1:0] be;
    logic signed [2*DATA_W-1:0] p;
    ae = a;
    be = b;
    p  = ae * be;
    return p;
  endfunction

  // Unsigned 64-bit product.
  function automatic logic [2*DATA_W-1:0] mul_unsigned(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
    return {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  endfunction

  // Signed divide on magnitudes: the quotient truncates toward zero and the
  // remainder takes the dividend's sign. The most negative value divided by
  // -1 wraps to itself with a zero remainder.
  function automatic logic [2*DATA_W-1:0] div_signed(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] ma;
    logic [DATA_W-1:0] mb;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    ma = a[DATA_W-1] ? -a : a;
    mb = b[DATA_W-1] ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[DATA_W-1] ^ b[DATA_W-1]) q = -q;
    if (a[DATA_W-1]) r = -r;
    return {r, q};
  endfunction

  // Unsigned divide, returned as {remainder, quotient}.
  function automatic logic [2*DATA_W-1:0] div_unsigned(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
    return {a % b, a / b};
  endfunction

  // Issue decode and {HI,LO} result for the operation on the inputs.
  // A zero divisor is replaced by 1 here only to keep the divider defined.
  // Its result is never used, because the shadow keeps the old HI/LO.
  always_comb begin
    res      = '0;
    is_div   = (op == OP_DIV) || (op == OP_DIVU);
    div_zero = is_div && (B == '0);
    start_ok = start && !op[2];
`ifdef MDU_CANCEL_EN
    start_ok = start_ok && !cancel;
`endif
    case (op)
      OP_MULT:  res = mul_signed(A, B);
      OP_MULTU: res = mul_unsigned(A, B);
      OP_DIV:   res = div_signed(A, div_zero ? DATA_W'(1) : B);
      OP_DIVU:  res = div_unsigned(A, div_zero ? DATA_W'(1) : B);
      default:  res = '0;
    endcase
  end

  // Latency counter, shadow capture, and HI/LO commit or move-to writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= CNT_IDLE;
      hi_n <= '0;
      lo_n <= '0;
      HI   <= '0;
      LO   <= '0;
    end else if (cnt == CNT_IDLE) begin
      if (start_ok) begin
        cnt <= is_div ? DIV_LAT : MULT_LAT;
        if (div_zero) begin
          hi_n <= HI;
          lo_n <= LO;
        end else begin
          hi_n <= res[2*DATA_W-1:DATA_W];
          lo_n <= res[DATA_W-1:0];
        end
      end else if (we && (op == OP_MTHI)) begin
        HI <= A;
      end else if (we && (op == OP_MTLO)) begin
        LO <= A;
      end
`ifdef MDU_CANCEL_EN
    end else if (cancel) begin
      cnt  <= CNT_IDLE;
      hi_n <= '0;
      lo_n <= '0;
`endif
    end else begin
      cnt <= cnt - CNT_LAST;
      if (cnt == CNT_LAST) begin
        HI <= hi_n;
        LO <= lo_n;
      end
    end
  end

  assign busy = (cnt != CNT_IDLE);

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: table-driven bench for mdu_unit with a result scoreboard.
// It also covers the cancel sequence when MDU_CANCEL_EN is defined.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        we;
  logic        cancel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .we    (we),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge with busy low. Issues one operation and pushes its
  // expected result. While busy, it optionally keeps start or we asserted
  // with junk data. When busy falls, it pops the expectation and compares.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int n, input int nstart, input int nwe);
    exp_t        e;
    int          cyc;
    bit          held;
    logic [31:0] ohi;
    logic [31:0] olo;
    ohi  = HI;
    olo  = LO;
    e.hi = ehi;
    e.lo = elo;
    e.n  = n;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    we    = 1'b0;
    @(negedge clk);
    cyc  = 0;
    held = 1'b1;
    while (busy && cyc < 64) begin
      if (HI !== ohi || LO !== olo) held = 1'b0;
      start = (cyc < nstart);
      we    = (cyc < nwe);
      op    = (cyc < nwe) ? ((cyc % 2) ? 3'd5 : 3'd4) : o;
      A     = $urandom;
      B     = $urandom;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    we    = 1'b0;
    e = sb.pop_front();
    chk({name, "_busy_len"}, 64'(cyc), 64'(e.n));
    chk({name, "_hold"}, 64'(held), 64'd1);
    chk({name, "_HI"}, 64'(HI), 64'(e.hi));
    chk({name, "_LO"}, 64'(LO), 64'(e.lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[4] = '{3'd3, 32'h00000100, 32'h00000007, 32'h00000004, 32'h00000024, 10};
    tbl[5] = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    tbl[6] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    tbl[7] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};

    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd0;
    A      = '0;
    B      = '0;
    we     = 1'b0;
    cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_HI", 64'(HI), 64'd0);
    chk("reset_LO", 64'(LO), 64'd0);

    // MTHI, then a divide by zero that must leave HI/LO untouched.
    we = 1'b1; op = 3'd4; A = 32'h12345678;
    @(negedge clk);
    we = 1'b0;
    chk("mthi_HI", 64'(HI), 64'h12345678);
    chk("mthi_busy", 64'(busy), 64'd0);
    run_op("divu_zero", 3'd3, 32'h00000005, 32'h0, 32'h12345678, 32'h0, 10, 0, 0);

    // Table, issued back to back in the first cycle busy is low.
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].hi, tbl[i].lo, tbl[i].n, 0, 0);

    // start held every busy cycle: only the first issue counts.
    run_op("mult_restart", 3'd0, 32'h00000006, 32'h00000007, 32'h0, 32'd42, 5, 5, 0);
    run_op("div_restart", 3'd2, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 10, 10, 0);
    // MTHI/MTLO writes during busy are dropped.
    run_op("multu_we", 3'd1, 32'h0000FFFF, 32'h00010001, 32'h0, 32'hFFFFFFFF, 5, 0, 5);

    // start with a non-issuing op, and we with a non-move op, are ignored.
    start = 1'b1; op = 3'd6; A = 32'hDEADBEEF; B = 32'h3;
    @(negedge clk);
    start = 1'b0;
    chk("op6_busy", 64'(busy), 64'd0);
    chk("op6_HILO", {HI, LO}, {32'h0, 32'hFFFFFFFF});
    we = 1'b1; op = 3'd0; A = 32'hDEADBEEF;
    @(negedge clk);
    we = 1'b0;
    chk("we_op0_HILO", {HI, LO}, {32'h0, 32'hFFFFFFFF});

    // Synchronous reset in the middle of a MULT aborts with no commit.
    start = 1'b1; op = 3'd0; A = 32'h3; B = 32'h4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_HILO", {HI, LO}, 64'd0);
    repeat (6) @(negedge clk);
    chk("midrst_late_HILO", {HI, LO}, 64'd0);

`ifdef MDU_CANCEL_EN
    we = 1'b1; op = 3'd5; A = 32'hCAFEF00D;
    @(negedge clk);
    we = 1'b0;
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("cancel_pre_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_HILO", {HI, LO}, {32'h0, 32'hCAFEF00D});
    repeat (12) @(negedge clk);
    chk("cancel_late_HILO", {HI, LO}, {32'h0, 32'hCAFEF00D});
    start = 1'b1; cancel = 1'b1; op = 3'd0; A = 32'h5; B = 32'h5;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", 64'(busy), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multi-cycle multiply/divide responder for the pipelined MIPS core, instantiated beside the E-stage ALU. The pipeline issues a one-cycle `start` request; the unit reports `busy` for a fixed latency, then commits the result to its HI/LO registers. Hazard logic stalls any MDU instruction in D while `start | busy` is high. HI/LO are read combinationally by mfhi/mflo in E.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu.
- `DIV_CYCLES`, default 10: busy duration for div/divu.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  issue strobe; single cycle; valid only for op codes 0–3.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op.
- `A`  in  32  rs operand, forwarded.
- `B`  in  32  rt operand, forwarded.
- `we`  in  1  write strobe for MTHI/MTLO; ignored for other ops.
- `cancel`  in  1  abort in-flight operation; present only with `MDU_CANCEL_EN`.
- `busy`  out  1  operation in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- Registers: `HI`, `LO`, shadow `hi_n`/`lo_n`, down-counter `cnt`. Width is `$clog2(max(MULT_CYCLES,DIV_CYCLES))+1`.
- State machine:
  - IDLE (`cnt==0`): when `start` is sampled with op 0–3, compute the result into the shadow regs. Load `cnt` with MULT_CYCLES or DIV_CYCLES, then go to RUN.
  - RUN: decrement each edge. On the edge where `cnt==1`, copy the shadow regs into HI/LO and return to IDLE.
- `busy = (cnt != 0)`, registered. There is no combinational path from `start` to `busy`.
- MULT: {HI,LO} = $signed(A)*$signed(B), 64-bit product.
- MULTU: {HI,LO} = A*B, unsigned 64-bit product.
- DIV: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: LO = A/B, HI = A%B, unsigned.
- Divide by zero (B==0, DIV or DIVU): the unit still goes busy for DIV_CYCLES, and HI/LO are left unchanged at commit.
- MTHI/MTLO (`we=1`, op 4/5, IDLE only): HI or LO ← A on that edge; `busy` stays low.
- Ignored inputs:
  - `start` or `we` while busy; hazard logic guarantees this cannot happen, and the unit ignores it regardless.
  - `start` with op 4–7.
  - `we` with op other than 4/5.
- Simultaneous `start` and `we` in IDLE: `start` wins and `we` is dropped.

## Timing
- Reset: `HI`=0, `LO`=0, `busy`=0, `cnt`=0, shadow regs 0. Reset during RUN aborts with no commit.
- `start` sampled at edge T:
  - `busy`=1 from T+ through the cycle before edge T+N, where N is the configured latency.
  - `busy` falls at edge T+N, and new HI/LO are visible in the same cycle.
  - `busy` is therefore high for exactly N cycles.
- Back-to-back issue: `start` is accepted in the first cycle where `busy`=0. Minimum issue interval is N+1 edges from one start to the next.
- MTHI/MTLO: value is visible on HI/LO the cycle after the `we` edge.
- HI/LO never change during RUN; reads during RUN return the old values.

## Configuration
- `MDU_CANCEL_EN` defined: adds the `cancel` input for exception/interrupt flush.
  - `cancel`=1 in RUN: `cnt` → 0 next edge, shadow discarded, HI/LO unchanged.
  - `cancel` takes priority over the commit edge.
  - `cancel` together with `start` in IDLE: the start is dropped.
- `MDU_CANCEL_EN` undefined: no `cancel` port; an operation always runs to completion.

## Test plan
- Reset, then MULT start with A=0xFFFFFFFE (−2), B=3 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- DIV cases, each after 10 busy cycles:
  - A=−7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0x12345678, then DIVU with B=0 → busy for 10 cycles; HI stays 0x12345678, LO stays 0.
- Back-to-back:
  - `start` asserted every cycle during a MULT → only the first is accepted.
  - A new MULT issued in the first cycle `busy`=0 → completes correctly.
  - `we` during busy → HI/LO unaffected.
- With `MDU_CANCEL_EN`: DIV started and `cancel` pulsed at busy cycle 4 → `busy` low the next cycle, HI/LO hold their old values. Synchronous `reset` mid-MULT → all outputs 0 the next cycle.
